// File: rtl/cpc_rom_ctrl.sv
// Upper-ROM decoder for the six-ROM CPC board. It snoops writes to the ROM select
// register and gates byte writes to the 28C256 devices behind an unlock sequence.
module cpc_rom_ctrl #(
    parameter int HOLDOFF_CYC = 40000,
    parameter int CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       A15,
    input  logic       A14,
    input  logic       A13,
    input  logic [7:0] D,
    input  logic       IOREQ_B,
    input  logic       MREQ_B,
    input  logic       RD_B,
    input  logic       WR_B,
    input  logic       ROMEN_B,
    input  logic [7:0] dip,
    output logic [2:0] rom_cs_b,
    output logic       roma14,
    output logic       romoe_b,
    output logic       rom_we_b,
    output logic       romdis,
    output logic       prog_active
);

    typedef enum logic [2:0] {IDLE, U1, U2, ARMED, PROG} state_t;

    state_t           state;
    logic [7:0]       rom_sel;
    logic [7:0]       target;
    logic [7:0]       d_cap;
    logic [CNT_W-1:0] holdoff;
    logic             sel_wr_q;
    logic             live_q;

    logic       sel_wr;
    logic       commit;
    logic       mem_wr;
    logic       hit;
    logic       live;
    logic       rd_act;
    logic [2:0] off;
    logic       unused_dip;

    // The 9-bit compare keeps B+5 from wrapping when the base sits near the top.
    function automatic logic in_range(input logic [7:0] v, input logic [4:0] cfg);
        logic [8:0] lo;
        lo = {5'b0, cfg[3:0]};
        return cfg[4] && ({1'b0, v} >= lo) && ({1'b0, v} <= lo + 9'd5);
    endfunction

    assign unused_dip = ^dip[7:5];
    assign sel_wr     = ~IOREQ_B & ~WR_B & ~A13;
    assign commit     = sel_wr_q & ~sel_wr;
    assign mem_wr     = ~MREQ_B & ~WR_B & A15 & A14;
    assign hit        = in_range(rom_sel, dip[4:0]);
    assign off        = rom_sel[2:0] - dip[2:0];
    assign rd_act     = ~ROMEN_B & A15 & A14 & hit;
    assign live       = (state == PROG) && (rom_sel == target) && (holdoff == '0)
                        && mem_wr && hit;
    assign prog_active = (state == PROG);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            rom_sel  <= 8'h00;
            target   <= 8'h00;
            d_cap    <= 8'h00;
            holdoff  <= '0;
            sel_wr_q <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            sel_wr_q <= sel_wr;
            live_q   <= live;
            if (sel_wr)
                d_cap <= D;
            if (commit) begin
                rom_sel <= d_cap;
                case (state)
                    IDLE:    state <= (d_cap == 8'hA5) ? U1 : IDLE;
                    U1:      state <= (d_cap == 8'h5A) ? U2 : IDLE;
                    U2:      state <= (d_cap == 8'hC3) ? ARMED : IDLE;
                    ARMED: begin
                        if (in_range(d_cap, dip[4:0])) begin
                            state  <= PROG;
                            target <= d_cap;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PROG:    state <= (d_cap == target) ? PROG : IDLE;
                    default: state <= IDLE;
                endcase
            end
            // The EEPROM starts its internal cycle when WR_B rises, so time from there.
            if (live_q && !mem_wr)
                holdoff <= CNT_W'(HOLDOFF_CYC);
            else if (holdoff != '0)
                holdoff <= holdoff - 1'b1;
        end
    end

    always_comb begin
        rom_cs_b = 3'b111;
        roma14   = 1'b0;
        romoe_b  = 1'b1;
        rom_we_b = 1'b1;
        romdis   = hit & ~ROMEN_B;
        if (live) begin
            rom_cs_b = ~(3'b001 << off[2:1]);
            roma14   = off[0];
            rom_we_b = 1'b0;
        end else if (rd_act) begin
            rom_cs_b = ~(3'b001 << off[2:1]);
            roma14   = off[0];
            romoe_b  = RD_B;
        end
    end

endmodule

// File: doc/cpc_rom_ctrl.md
Name: cpc_rom_ctrl

Overview:
- CPLD-resident controller for the six-ROM board.
- Tracks the CPC upper-ROM select register by snooping IO writes with A13=0.
- Decodes upper-ROM reads onto three dual-bank 28C256 devices: per-chip CS, shared OE, bank bit ROMA14, and ROMDIS.
- Adds a guarded in-system EEPROM programming mode: a magic unlock sequence, then byte-write strobes with a per-write busy holdoff.

Parameters:
- HOLDOFF_CYC, 40000, CLK cycles writes are blocked after each EEPROM byte write (10 ms at 4 MHz).
- CNT_W, 16, width of the holdoff counter; must satisfy 2^CNT_W > HOLDOFF_CYC.

Ports:
- CLK  in  1  CPC 4 MHz bus clock; the single clock.
- RESET  in  1  asynchronous, active-high reset.
- A15, A14, A13  in  1 each  CPU address bits.
- D  in  8  CPU data bus; the block only samples it.
- IOREQ_B, MREQ_B, RD_B, WR_B, ROMEN_B  in  1 each  CPC bus strobes, active-low.
- dip  in  8  config: dip[3:0] = base ROM number B; dip[4] = board enable; dip[7:5] reserved, ignored.
- rom_cs_b  out  3  active-low chip selects, index 0 = ROM01, 1 = ROM23, 2 = ROM45.
- roma14  out  1  bank-within-chip select.
- romoe_b  out  1  shared output enable, active-low.
- rom_we_b  out  1  shared EEPROM write enable, active-low.
- romdis  out  1  ROMDIS drive (through the board diode).
- prog_active  out  1  high while in PROG state.

Behaviour:
- Reset (async, RESET=1): rom_sel=0x00, fsm=IDLE, holdoff=0, strobe history cleared.
- Reset output values (combinational, from reset state): rom_cs_b=3'b111, romoe_b=1, rom_we_b=1, romdis=0, roma14=0, prog_active=0.
- Select-write detect:
  - sel_wr = ~IOREQ_B & ~WR_B & ~A13, sampled each CLK.
  - While sel_wr=1, D is captured into d_cap every cycle.
  - Commit on the falling edge of sampled sel_wr (prev=1, now=0): rom_sel<=d_cap.
  - New rom_sel is visible to decode from the cycle after commit (1-cycle latency).
- In-range test: hit = dip[4] & (rom_sel >= B) & (rom_sel <= B+5), using a 9-bit compare.
  - Where B+5 > 255 the range is truncated; no wrap.
  - Offset off = rom_sel - B (0..5) gives chip = off>>1 and bank = off[0].
- Read decode: active when upper = ~ROMEN_B & A15 & A14 and hit=1.
  - romdis = hit & ~ROMEN_B (combinational).
  - rom_cs_b[chip]=0, roma14=bank, romoe_b = RD_B.
  - Outside a decoded read: all CS high, romoe_b high.
- Unlock FSM states: IDLE, U1, U2, ARMED, PROG. Transitions are evaluated only on select-write commits.
  - IDLE: value 0xA5 -> U1; any other value stays IDLE.
  - U1: 0x5A -> U2; else IDLE.
  - U2: 0xC3 -> ARMED; else IDLE.
  - ARMED: next value V with V in range -> PROG, target<=V; V out of range -> IDLE.
  - PROG: any commit with value != target -> IDLE; value == target stays PROG.
  - Every commit, including magic values, also updates rom_sel. Magic values are >15 and normally miss the board range.
- Programming:
  - mem_wr = ~MREQ_B & ~WR_B & A15 & A14.
  - Write is live when fsm=PROG, rom_sel==target, holdoff==0 and mem_wr=1. During a live write: rom_cs_b[chip]=0, roma14=bank, romoe_b=1, rom_we_b=0, all combinational.
  - On the falling edge of sampled mem_wr while live, load holdoff=HOLDOFF_CYC; it decrements once per CLK to 0.
  - While holdoff != 0, rom_we_b is held at 1; reads remain allowed (data polling).
  - A write attempted during holdoff is ignored and does not reload the counter.
- Simultaneous events: a select commit that leaves PROG takes effect the same cycle; holdoff keeps counting and a new PROG entry still waits for 0.
- dip[4]=0 forces hit=0; no outputs are asserted, but the FSM still tracks commits.
- RESET mid-write forces rom_we_b=1 immediately (async).

Test Plan:
- Reset → all CS high, romoe_b=1, rom_we_b=1, romdis=0; then read at 0xC000 with ROMEN_B=0 → no CS asserted, romdis=0.
- dip=0x13 (B=3, enabled); OUT 0xDF00,0x06; read 0xC123 → romdis=1, rom_cs_b=3'b101, roma14=1, romoe_b follows RD_B; sel=0x09 → no CS, romdis=0.
- OUT 0xA5,0x5A,0xC3,0x04 (B=3) → prog_active=1 one cycle after the last commit; memory write 0xC000 → rom_cs_b=3'b110, roma14=1, rom_we_b=0 during WR_B low.
- Second write 2 cycles after the first → rom_we_b stays 1; after HOLDOFF_CYC cycles, write → rom_we_b=0.
- Sequence 0xA5,0x00,0x5A,0xC3,0x04 → FSM ends IDLE, prog_active=0, memory write gives rom_we_b=1.
- In PROG, assert RESET during a write → rom_we_b=1 within the same cycle, fsm=IDLE, rom_sel=0.
